reduction_tree: RTL
===================

REDUCTION_TREE -- requirements
Module: reduction_tree

Interface
REQ-001 SHALL have parameter N_IN, default 32, meaning lane count; power of two, at least 2; L = log2(N_IN).
REQ-002 SHALL have parameter W_IN, default 16, meaning signed lane width.
REQ-003 SHALL have parameter W_OUT, default 16, meaning signed result width.
REQ-004 SHALL have parameter ACC_EXTRA, default 8, meaning accumulator guard bits; W_ACC = W_IN + L + ACC_EXTRA.
REQ-005 SHALL have parameter AVG_SHIFT, default 5, meaning right-shift applied in AVG mode.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port in_valid, input, 1, meaning an input beat is offered.
REQ-010 SHALL have port in_ready, output, 1, meaning a beat is accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port in_data, input, N_IN*W_IN, meaning packed signed lanes; lane i = bits [i*W_IN +: W_IN].
REQ-012 SHALL have port in_mask, input, N_IN, meaning lane enable; 0 substitutes the mode identity.
REQ-013 SHALL have port in_last, input, 1, meaning the final beat of a frame.
REQ-014 SHALL have port in_mode, input, 2, meaning 0=SUM, 1=MAX, 2=AVG, 3=SUM.
REQ-015 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-016 SHALL have port out_ready, input, 1, meaning the downstream accepts the result.
REQ-017 SHALL have port out_data, output, W_OUT, meaning the signed frame result.
REQ-018 SHALL have port out_sat, output, 1, meaning out_data was clamped.

Function
REQ-019 SHALL compute masked lanes as identity: 0 in SUM/AVG; -2^(W_IN-1) in MAX.
REQ-020 SHALL reduce pairwise through L registered stages (sum or signed max); stage k width W_IN+k for SUM, W_IN for MAX; no internal overflow possible.
REQ-021 SHALL carry valid, last and frame mode alongside each stage.
REQ-022 SHALL latch frame mode from in_mode on the first beat of a frame (first beat after reset or after a last beat); in_mode on later beats of that frame is ignored.
REQ-023 SHALL hold a W_ACC-bit accumulator initialised to identity; per tree result, SUM/AVG: acc+tree, MAX: max(acc,tree).
REQ-024 SHALL on a last tree result load out_data with the finalised value, set out_valid, and return acc to identity in the same cycle.
REQ-025 SHALL finalise AVG as arithmetic shift right by AVG_SHIFT (floor), then all modes clamp to [-2^(W_OUT-1), 2^(W_OUT-1)-1]; out_sat=1 iff clamped.
REQ-026 SHALL saturate the accumulator at W_ACC limits and mark the frame saturated; out_sat then reads 1.
REQ-027 SHALL produce out_valid exactly L+1 cycles after acceptance of the last beat when not stalled.
REQ-028 SHALL define stall = out_valid & ~out_ready; while stalled no pipeline stage, accumulator or output register advances, and in_ready=0.
REQ-029 SHALL drive in_ready = ~stall (combinational); otherwise beats are accepted every cycle.
REQ-030 SHALL hold out_data/out_sat stable while out_valid & ~out_ready; clear out_valid on handshake unless a new result loads the same cycle.
REQ-031 SHALL emit results in frame order without loss or duplication; single-beat frames (in_last on the first beat) are legal.
REQ-032 SHALL treat in_data/in_mask/in_last/in_mode as don't-care when in_valid=0; bubbles do not disturb the accumulator.

Reset
REQ-033 SHALL on rst_n=0 asynchronously clear all stage valids, out_valid=0, out_data=0, out_sat=0, acc=identity of SUM, frame-open flag=0; in_ready=1 after release.
REQ-034 SHALL discard any partial frame on reset; the first beat after release opens a new frame.

Verification (N_IN=32, W_IN=16, W_OUT=16, AVG_SHIFT=5, L=5)
REQ-035 SHALL cover: all lanes=1, mask all ones, SUM, single last beat -> out_data=32, out_sat=0, out_valid 6 cycles after acceptance.
REQ-036 SHALL cover: lane i=i-16, mask=0x0000000F, MAX -> out_data=-13; repeated with mask=0 -> -32768, out_sat=0.
REQ-037 SHALL cover: all lanes=32767, SUM, 4 beats with last on the 4th -> out_data=32767, out_sat=1; next frame of all lanes=1 -> 32, out_sat=0.
REQ-038 SHALL cover: AVG, all lanes=-3 -> -3; lanes sum -97 -> -4 (floor).
REQ-039 SHALL cover: 3 back-to-back single-beat frames with out_ready low for 10 cycles -> in_ready low while stalled, first result held stable, all three delivered in order after release.
REQ-040 SHALL cover: rst_n pulsed low mid-frame after 2 of 4 beats -> out_valid=0 immediately; the next 1-beat frame of all lanes=2 -> 64.

Source files
------------

// File: rtl/reduction_tree.sv
// Pipelined masked reduction tree (SUM / MAX / AVG) over N_IN signed lanes,
// with a per-frame accumulator, saturating finaliser and a stallable
// valid/ready output stage. Latency from accepted beat to result is L+1.
module reduction_tree #(
    parameter int N_IN      = 32,
    parameter int W_IN      = 16,
    parameter int W_OUT     = 16,
    parameter int ACC_EXTRA = 8,
    parameter int AVG_SHIFT = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*W_IN-1:0]   in_data,
    input  logic [N_IN-1:0]        in_mask,
    input  logic                   in_last,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_OUT-1:0]       out_data,
    output logic                   out_sat
);
    localparam int L     = $clog2(N_IN);
    localparam int W_T   = W_IN + L;
    localparam int W_ACC = W_IN + L + ACC_EXTRA;

    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_AVG = 2'd2;

    localparam logic signed [W_ACC:0]   ACC_MAX = {2'b00, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC:0]   ACC_MIN = {2'b11, {(W_ACC-1){1'b0}}};
    localparam logic signed [W_ACC-1:0] OUT_MAX = {{(W_ACC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] OUT_MIN = {{(W_ACC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    // Identity substituted for a masked lane, already widened to tree width.
    function automatic logic signed [W_T-1:0] lane_ident(input logic is_max);
        return is_max ? {{(L+1){1'b1}}, {(W_IN-1){1'b0}}} : '0;
    endfunction

    // One tree node: signed max or sum. Tree width W_IN+L cannot overflow.
    function automatic logic signed [W_T-1:0] combine(input logic signed [W_T-1:0] a,
                                                      input logic signed [W_T-1:0] b,
                                                      input logic is_max);
        if (is_max) return (a > b) ? a : b;
        return a + b;
    endfunction

    function automatic logic acc_ovf(input logic signed [W_ACC:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    function automatic logic signed [W_ACC-1:0] acc_clip(input logic signed [W_ACC:0] v);
        if (v > ACC_MAX) return ACC_MAX[W_ACC-1:0];
        if (v < ACC_MIN) return ACC_MIN[W_ACC-1:0];
        return v[W_ACC-1:0];
    endfunction

    function automatic logic out_ovf(input logic signed [W_ACC-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic [W_OUT-1:0] out_clip(input logic signed [W_ACC-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[W_OUT-1:0];
        if (v < OUT_MIN) return OUT_MIN[W_OUT-1:0];
        return v[W_OUT-1:0];
    endfunction

    logic                   stall;
    logic                   en;
    logic                   in_fire;
    logic                   frame_open;
    logic [1:0]             frame_mode;
    logic [1:0]             mode_cur;

    // Stage 0 holds the masked input lanes; stage k holds N_IN>>k partial results.
    logic signed [W_T-1:0]  node_p [0:L][0:N_IN-1];
    logic [1:0]             md_p   [0:L];
    logic [L:0]             lst_p;
    logic [L:0]             vld_p;

    logic signed [W_ACC-1:0] acc;
    logic                    acc_empty;
    logic                    sat_frame;

    logic                    l_max;
    logic                    l_avg;
    logic signed [W_ACC-1:0] tree_ext;
    logic signed [W_ACC:0]   sum_wide;
    logic signed [W_ACC-1:0] acc_new;
    logic                    sat_new;
    logic signed [W_ACC-1:0] fin;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;
    assign in_fire  = in_valid & en;
    // Later beats of an open frame reuse the mode latched on its first beat.
    assign mode_cur = frame_open ? frame_mode : in_mode;

    // Accumulate the tree result and finalise it (AVG shift, output clamp).
    always_comb begin
        l_max    = (md_p[L] == MODE_MAX);
        l_avg    = (md_p[L] == MODE_AVG);
        tree_ext = W_ACC'(node_p[L][0]);
        sum_wide = (W_ACC+1)'(acc) + (W_ACC+1)'(tree_ext);
        acc_new  = tree_ext;
        sat_new  = 1'b0;
        if (!acc_empty) begin
            if (l_max) begin
                acc_new = (acc > tree_ext) ? acc : tree_ext;
                sat_new = sat_frame;
            end else begin
                acc_new = acc_clip(sum_wide);
                sat_new = sat_frame | acc_ovf(sum_wide);
            end
        end
        fin = l_avg ? (acc_new >>> AVG_SHIFT) : acc_new;
    end

    // Datapath registers: input masking (stage 0) and pairwise reduction stages 1..L.
    always_ff @(posedge clk) begin
        if (en) begin
            md_p[0]  <= mode_cur;
            lst_p[0] <= in_last;
            for (int i = 0; i < N_IN; i++) begin
                node_p[0][i] <= in_mask[i] ? W_T'($signed(in_data[i*W_IN +: W_IN]))
                                           : lane_ident(mode_cur == MODE_MAX);
            end
            for (int k = 1; k <= L; k++) begin
                md_p[k]  <= md_p[k-1];
                lst_p[k] <= lst_p[k-1];
                for (int i = 0; i < (N_IN >> k); i++) begin
                    node_p[k][i] <= combine(node_p[k-1][2*i], node_p[k-1][2*i+1],
                                            md_p[k-1] == MODE_MAX);
                end
            end
        end
    end

    // Control, frame tracking, accumulator and output register; all freeze on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p      <= '0;
            frame_open <= 1'b0;
            frame_mode <= 2'd0;
            acc        <= '0;
            acc_empty  <= 1'b1;
            sat_frame  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sat    <= 1'b0;
        end else if (en) begin
            vld_p <= {vld_p[L-1:0], in_fire};
            if (in_fire) begin
                frame_open <= ~in_last;
                if (!frame_open) frame_mode <= in_mode;
            end
            if (vld_p[L]) begin
                if (lst_p[L]) begin
                    acc       <= '0;
                    acc_empty <= 1'b1;
                    sat_frame <= 1'b0;
                end else begin
                    acc       <= acc_new;
                    acc_empty <= 1'b0;
                    sat_frame <= sat_new;
                end
            end
            out_valid <= vld_p[L] & lst_p[L];
            if (vld_p[L] & lst_p[L]) begin
                out_data <= out_clip(fin);
                out_sat  <= sat_new | out_ovf(fin);
            end
        end
    end
endmodule
